// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the fetch PC, drives the instruction-memory handshake,
// applies EX/WB redirects and buffers one fetched instruction toward decode.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    output logic [31:0] pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              inst_req_q, inst_req_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [XLEN-1:0]   if_inst_q, if_inst_d;

    logic              redir;
    logic [XLEN-1:0]   redir_target;
    logic [XLEN-1:0]   pc_next_seq;

    // Exception/ertn outranks branch; targets are forced word-aligned.
    assign redir        = exc_valid | br_valid;
    assign redir_target = {(exc_valid ? exc_target[XLEN-1:2] : br_target[XLEN-1:2]), 2'b00};
    assign pc_next_seq  = pc_q + XLEN'(4);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir) pc_d = redir_target;
            end
            S_REQ: begin
                if (redir) pc_d = redir_target;
                if (inst_gnt) state_d = redir ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (redir) pc_d = redir_target;
                if (inst_rvalid) begin
                    if (redir) begin
                        state_d = S_REQ;
                    end else begin
                        if_inst_d = inst_rdata;
                        if_pc_d   = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (redir) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale response must drain before a new request may issue.
                if (redir) pc_d = redir_target;
                if (inst_rvalid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_target;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    pc_d    = pc_next_seq;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inst_req_d = (state_d == S_REQ);
        if_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_req_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_req_q <= inst_req_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign inst_req  = inst_req_q;
    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: random memory/decode/redirect traffic against a transaction-level
// reference model, plus directed scenarios for the fetch sequence, stalls, redirects, wrap and reset.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exc_valid, br_valid;
    logic [31:0] exc_target, br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        id_ready;
    logic [31:0] pc;

    fetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstn(rstn),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .br_valid(br_valid), .br_target(br_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pending request, one accepted fetch (possibly stale), one buffer slot.
    logic [31:0] m_pc, m_bpc, m_binst;
    bit          m_idle, m_req, m_out, m_stale, m_buf;

    task automatic model_step();
        logic [31:0] tgt, old_pc;
        bit redir;
        if (!rstn) begin
            m_pc = RESET_PC; m_bpc = '0; m_binst = '0;
            m_idle = 1; m_req = 0; m_out = 0; m_stale = 0; m_buf = 0;
            return;
        end
        redir  = exc_valid || br_valid;
        tgt    = exc_valid ? exc_target : br_target;
        tgt    = tgt & 32'hffff_fffc;
        old_pc = m_pc;
        if (m_idle) begin
            m_idle = 0; m_req = 1;
            if (redir) m_pc = tgt;
        end else if (m_req) begin
            if (redir) m_pc = tgt;
            if (inst_gnt) begin
                m_req = 0; m_out = 1; m_stale = redir;
            end
        end else if (m_out) begin
            if (redir) m_pc = tgt;
            if (inst_rvalid) begin
                m_out = 0;
                if (m_stale || redir) m_req = 1;
                else begin
                    m_buf = 1; m_bpc = old_pc; m_binst = inst_rdata;
                end
            end else if (redir) begin
                m_stale = 1;
            end
        end else if (m_buf) begin
            if (redir) begin
                m_buf = 0; m_req = 1; m_pc = tgt;
            end else if (id_ready) begin
                m_buf = 0; m_req = 1; m_pc = old_pc + 32'd4;
            end
        end
    endtask

    // Stimulus knobs
    int gnt_pct = 100, ready_pct = 100, dmin = 0, dmax = 0;
    bit rnd_mode = 0;
    bit pend = 0;
    int dly = 0;

    task automatic step();
        bit fired, rv;
        fired = inst_req && inst_gnt;
        rv    = inst_rvalid;
        @(posedge clk);
        model_step();
        #1;
        check("inst_req", 32'(inst_req), 32'(m_req));
        check("inst_addr", inst_addr, m_pc);
        check("pc", pc, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_buf));
        check("if_pc", if_pc, m_bpc);
        check("if_inst", if_inst, m_binst);
        // Memory responder: one outstanding read, response after dly cycles.
        if (!rstn) pend = 0;
        else begin
            if (rv) pend = 0;
            if (fired) begin
                pend = 1;
                dly = $urandom_range(dmax, dmin);
            end
        end
        inst_rvalid = 1'b0;
        if (pend) begin
            if (dly == 0) inst_rvalid = 1'b1;
            else dly--;
        end
        inst_rdata = $urandom;
        inst_gnt   = inst_req && ($urandom_range(99) < 32'(gnt_pct));
        id_ready   = $urandom_range(99) < 32'(ready_pct);
        br_valid   = 1'b0;
        exc_valid  = 1'b0;
        if (rnd_mode) begin
            br_valid   = $urandom_range(99) < 8;
            exc_valid  = $urandom_range(99) < 3;
            br_target  = $urandom;
            exc_target = ($urandom_range(9) == 0) ? 32'hffff_fffe : $urandom;
            rstn       = ($urandom_range(199) != 0);
        end
    endtask

    logic [31:0] addr_q[$];
    logic [31:0] p;
    bit          seen;

    initial begin
        rstn = 0; exc_valid = 0; br_valid = 0; exc_target = '0; br_target = '0;
        inst_gnt = 0; inst_rvalid = 0; inst_rdata = '0; id_ready = 0;

        // Reset values
        step(); step();
        check("rst_pc", pc, RESET_PC);
        check("rst_req", 32'(inst_req), 0);
        check("rst_ifv", 32'(if_valid), 0);
        check("rst_ifpc", if_pc, 0);
        rstn = 1;

        // Streaming fetch, always granted, 1-cycle response, decode always ready
        for (int i = 0; i < 12; i++) begin
            if (inst_req && inst_gnt) addr_q.push_back(inst_addr);
            step();
        end
        check("seq_cnt", 32'(addr_q.size() >= 3), 1);
        if (addr_q.size() >= 3) begin
            check("seq0", addr_q[0], 32'h1c000000);
            check("seq1", addr_q[1], 32'h1c000004);
            check("seq2", addr_q[2], 32'h1c000008);
        end

        // HOLD stall with id_ready low, then handoff
        ready_pct = 0; id_ready = 0;
        for (int i = 0; i < 20 && !if_valid; i++) step();
        check("hold_reach", 32'(if_valid), 1);
        p = pc;
        for (int i = 0; i < 5; i++) step();
        check("hold_ifv", 32'(if_valid), 1);
        check("hold_pc", pc, p);
        check("hold_req", 32'(inst_req), 0);
        ready_pct = 100; id_ready = 1;
        step();
        check("handoff_pc", pc, p + 32'd4);

        // Branch while WAIT, no response yet -> stale response dropped
        dmin = 4; dmax = 4;
        for (int i = 0; i < 20 && !(inst_req && inst_gnt); i++) step();
        check("br_gnt", 32'(inst_req && inst_gnt), 1);
        step();
        br_valid = 1; br_target = 32'h1c000103;
        step();
        check("br_pc", pc, 32'h1c000100);
        check("br_noreq", 32'(inst_req), 0);
        seen = 0;
        for (int i = 0; i < 20 && !inst_req; i++) begin
            step();
            seen |= if_valid;
        end
        check("br_dropped", 32'(seen), 0);
        check("br_addr", inst_addr, 32'h1c000100);

        // Simultaneous exception and branch: exception wins
        dmin = 0; dmax = 0;
        step(); step();
        exc_valid = 1; exc_target = 32'h1c001000;
        br_valid = 1; br_target = 32'h1c000200;
        step();
        for (int i = 0; i < 20 && !inst_req; i++) step();
        check("exc_addr", inst_addr, 32'h1c001000);

        // Grant stall with redirect mid-stall
        gnt_pct = 0; inst_gnt = 0;
        for (int i = 0; i < 20 && !inst_req; i++) step();
        step();
        br_valid = 1; br_target = 32'h1c000300;
        step();
        check("stall_addr", inst_addr, 32'h1c000300);
        check("stall_req", 32'(inst_req), 1);
        step();
        check("stall_hold", 32'(inst_req), 1);
        gnt_pct = 100; inst_gnt = 1;
        step();
        check("stall_gnt", 32'(inst_req), 0);

        // PC wrap at the top of the address space
        step();
        br_valid = 1; br_target = 32'hfffffffc;
        step();
        for (int i = 0; i < 30 && !(if_valid && if_pc == 32'hfffffffc); i++) step();
        check("wrap_hold", if_pc, 32'hfffffffc);
        step();
        for (int i = 0; i < 10 && !inst_req; i++) step();
        check("wrap_addr", inst_addr, 32'h0);

        // Reset while a fetch is outstanding
        dmin = 5; dmax = 5;
        for (int i = 0; i < 20 && !(inst_req && inst_gnt); i++) step();
        step();
        rstn = 0;
        step();
        check("rst2_req", 32'(inst_req), 0);
        check("rst2_ifv", 32'(if_valid), 0);
        check("rst2_pc", pc, RESET_PC);
        rstn = 1;
        for (int i = 0; i < 10 && !inst_req; i++) step();
        check("rst2_addr", inst_addr, RESET_PC);

        // Random traffic
        gnt_pct = 60; ready_pct = 60; dmin = 0; dmax = 3; rnd_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd_mode = 0; rstn = 1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
